// File: rtl/fifo_sync_pkg.sv
// Shared types and helpers for the programmable synchronous FIFO.
package fifo_sync_pkg;

  localparam int unsigned FIFO_MAX_DEPTH = 1024;

  typedef enum logic {
    FIFO_MODE_REG  = 1'b0,
    FIFO_MODE_FWFT = 1'b1
  } fifo_mode_e;

  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_ram_sdp.sv
// Simple dual-port storage array: one write port, one read port that is either
// combinational (REG_OUT=0) or registered on re_i (REG_OUT=1, cleared by rst_i).
module fifo_ram_sdp #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned DEPTH   = 16,
  parameter bit          REG_OUT = 1'b0
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     re_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  generate
    if (REG_OUT) begin : g_reg
      logic [WIDTH-1:0] rdata_q;

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          rdata_q <= '0;
        end else if (re_i) begin
          rdata_q <= mem_q[raddr_i];
        end
      end

      assign rdata_o = rdata_q;
    end else begin : g_comb
      logic unused_rd_ctl;

      assign unused_rd_ctl = rst_i ^ re_i;
      assign rdata_o       = mem_q[raddr_i];
    end
  endgenerate

endmodule

// File: rtl/fifo_sync_prog.sv
// Synchronous FIFO, any depth 2..1024, programmable almost flags, FWFT or registered read.
// Define FIFO_SYNC_PROG_ERR_EN to build the sticky overflow/underflow registers.
module fifo_sync_prog
  import fifo_sync_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned AF_LEVEL = DEPTH - 2,
  parameter int unsigned AE_LEVEL = 2,
  parameter int unsigned FWFT     = 1
) (
  input  logic                        clk,
  input  logic                        rest,
  input  logic                        flush,
  input  logic                        write,
  input  logic [WIDTH-1:0]            write_data,
  input  logic                        read,
  output logic [WIDTH-1:0]            read_data,
  output logic                        full,
  output logic                        empty,
  output logic                        almost_full,
  output logic                        almost_empty,
  output logic [cnt_width(DEPTH)-1:0] count,
  output logic                        overflow,
  output logic                        underflow
);

  localparam int unsigned CW      = cnt_width(DEPTH);
  localparam int unsigned AW      = $clog2(DEPTH);
  localparam fifo_mode_e  MODE    = (FWFT != 0) ? FIFO_MODE_FWFT : FIFO_MODE_REG;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);
  localparam logic [AW-1:0] LAST_C  = AW'(DEPTH - 1);

  generate
    if (DEPTH < 2 || DEPTH > FIFO_MAX_DEPTH) begin : g_bad_depth
      $error("fifo_sync_prog: DEPTH=%0d outside 2..%0d", DEPTH, FIFO_MAX_DEPTH);
    end
    if (!(AE_LEVEL < AF_LEVEL && AF_LEVEL <= DEPTH)) begin : g_bad_levels
      $error("fifo_sync_prog: need AE_LEVEL(%0d) < AF_LEVEL(%0d) <= DEPTH(%0d)",
             AE_LEVEL, AF_LEVEL, DEPTH);
    end
    if (WIDTH < 1 || WIDTH > 256) begin : g_bad_width
      $error("fifo_sync_prog: WIDTH=%0d outside 1..256", WIDTH);
    end
  endgenerate

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  logic          full_q, empty_q, af_q, ae_q;
  logic          wr_acc, rd_acc;
  logic          ram_we, ram_re;

  // Explicit wrap compare keeps non-power-of-two depths correct.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == LAST_C) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    wr_acc   = write && (!full_q || read);
    rd_acc   = read && !empty_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_acc) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (rd_acc) rd_ptr_d = ptr_inc(rd_ptr_q);
      if (wr_acc && !rd_acc) begin
        count_d = count_q + 1'b1;
      end else if (rd_acc && !wr_acc) begin
        count_d = count_q - 1'b1;
      end
    end
    ram_we = wr_acc && !flush && !rest;
    ram_re = rd_acc && !flush;
  end

  // Flags are computed from the next count so they line up with count itself.
  always_ff @(posedge clk) begin
    if (rest) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= (count_d == DEPTH_C);
      empty_q  <= (count_d == '0);
      af_q     <= (count_d >= AF_C);
      ae_q     <= (count_d <= AE_C);
    end
  end

  fifo_ram_sdp #(
    .WIDTH   (WIDTH),
    .DEPTH   (DEPTH),
    .REG_OUT (MODE == FIFO_MODE_REG)
  ) u_ram (
    .clk_i   (clk),
    .rst_i   (rest),
    .we_i    (ram_we),
    .waddr_i (wr_ptr_q),
    .wdata_i (write_data),
    .re_i    (ram_re),
    .raddr_i (rd_ptr_q),
    .rdata_o (read_data)
  );

  assign count        = count_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;

`ifdef FIFO_SYNC_PROG_ERR_EN
  logic ovf_q, udf_q, ovf_evt, udf_evt;

  assign ovf_evt = write && full_q && !read;
  // A read on an empty FIFO alongside a write is not a refusal of data.
  assign udf_evt = read && empty_q && !write;

  always_ff @(posedge clk) begin
    if (rest || flush) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (ovf_evt) ovf_q <= 1'b1;
      if (udf_evt) udf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rest && !flush) begin
      assert (!ovf_evt) else $warning("fifo_sync_prog: write refused while full");
      assert (!udf_evt) else $warning("fifo_sync_prog: read refused while empty");
    end
  end

  assign overflow  = ovf_q;
  assign underflow = udf_q;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_sync_prog.sv
// Randomised and directed checks of two fifo_sync_prog configurations against a queue model.
module tb_fifo_sync_prog;

`ifdef FIFO_SYNC_PROG_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rest, flush, write, read;
  logic [7:0] wdata;

  always #5 clk = ~clk;

  logic [7:0] a_rd, b_rd;
  logic       a_full, a_empty, a_af, a_ae, a_ovf, a_udf;
  logic       b_full, b_empty, b_af, b_ae, b_ovf, b_udf;
  logic [2:0] a_cnt;
  logic [4:0] b_cnt;

  fifo_sync_prog #(.WIDTH(8), .DEPTH(5), .AF_LEVEL(3), .AE_LEVEL(2), .FWFT(1)) u_a (
    .clk(clk), .rest(rest), .flush(flush), .write(write), .write_data(wdata),
    .read(read), .read_data(a_rd), .full(a_full), .empty(a_empty),
    .almost_full(a_af), .almost_empty(a_ae), .count(a_cnt),
    .overflow(a_ovf), .underflow(a_udf)
  );

  fifo_sync_prog #(.WIDTH(8), .DEPTH(16), .AF_LEVEL(12), .AE_LEVEL(3), .FWFT(0)) u_b (
    .clk(clk), .rest(rest), .flush(flush), .write(write), .write_data(wdata),
    .read(read), .read_data(b_rd), .full(b_full), .empty(b_empty),
    .almost_full(b_af), .almost_empty(b_ae), .count(b_cnt),
    .overflow(b_ovf), .underflow(b_udf)
  );

  int unsigned nvec = 0;
  int unsigned nerr = 0;

  task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: one queue per DUT, index 0 = A, 1 = B.
  int unsigned m_depth [2] = '{5, 16};
  int unsigned m_af    [2] = '{3, 12};
  int unsigned m_ae    [2] = '{2, 3};
  bit          m_fwft  [2] = '{1'b1, 1'b0};
  logic [7:0]  mq      [2][$];
  logic [7:0]  m_rreg  [2];
  bit          m_ovf   [2];
  bit          m_udf   [2];
  bit          chk_en = 1'b0;

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      int unsigned n;
      bit          wa, ra;
      logic [7:0]  v;
      n = mq[k].size();
      if (rest) begin
        mq[k].delete();
        m_ovf[k]  = 1'b0;
        m_udf[k]  = 1'b0;
        m_rreg[k] = 8'h00;
      end else if (flush) begin
        mq[k].delete();
        m_ovf[k] = 1'b0;
        m_udf[k] = 1'b0;
      end else begin
        wa = write && (n < m_depth[k] || read);
        ra = read && (n > 0);
        if (ERR_EN && write && n == m_depth[k] && !read) m_ovf[k] = 1'b1;
        if (ERR_EN && read && n == 0 && !write) m_udf[k] = 1'b1;
        if (ra) begin
          v = mq[k].pop_front();
          if (!m_fwft[k]) m_rreg[k] = v;
        end
        if (wa) mq[k].push_back(wdata);
      end
    end
    if (rest) chk_en = 1'b1;
  end

  always @(posedge clk) begin
    #2;
    if (chk_en) begin
      chk("A.count", 32'(a_cnt), mq[0].size());
      chk("A.full",  32'(a_full),  32'(mq[0].size() == m_depth[0]));
      chk("A.empty", 32'(a_empty), 32'(mq[0].size() == 0));
      chk("A.af",    32'(a_af),    32'(mq[0].size() >= m_af[0]));
      chk("A.ae",    32'(a_ae),    32'(mq[0].size() <= m_ae[0]));
      chk("A.ovf",   32'(a_ovf),   32'(m_ovf[0]));
      chk("A.udf",   32'(a_udf),   32'(m_udf[0]));
      if (mq[0].size() > 0) chk("A.rdata", 32'(a_rd), 32'(mq[0][0]));
      chk("B.count", 32'(b_cnt), mq[1].size());
      chk("B.full",  32'(b_full),  32'(mq[1].size() == m_depth[1]));
      chk("B.empty", 32'(b_empty), 32'(mq[1].size() == 0));
      chk("B.af",    32'(b_af),    32'(mq[1].size() >= m_af[1]));
      chk("B.ae",    32'(b_ae),    32'(mq[1].size() <= m_ae[1]));
      chk("B.ovf",   32'(b_ovf),   32'(m_ovf[1]));
      chk("B.udf",   32'(b_udf),   32'(m_udf[1]));
      chk("B.rdata", 32'(b_rd),    32'(m_rreg[1]));
    end
  end

  task automatic cyc(input bit w, input logic [7:0] d, input bit r, input bit f, input bit rs);
    @(negedge clk);
    write = w;
    wdata = d;
    read  = r;
    flush = f;
    rest  = rs;
    @(posedge clk);
    #3;
  endtask

  initial begin
    int unsigned pw, pr;
    rest  = 1'b1;
    flush = 1'b0;
    write = 1'b0;
    read  = 1'b0;
    wdata = 8'h00;

    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("A.cnt_rst",   32'(a_cnt),   0);
    chk("A.empty_rst", 32'(a_empty), 1);
    chk("A.full_rst",  32'(a_full),  0);
    chk("A.ae_rst",    32'(a_ae),    1);
    chk("A.af_rst",    32'(a_af),    0);
    chk("B.rd_rst",    32'(b_rd),    0);

    // Fill A to DEPTH=5, then a refused sixth write.
    for (int i = 1; i <= 5; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
    chk("A.full_5",  32'(a_full), 1);
    chk("A.cnt_5",   32'(a_cnt),  5);
    chk("M.size_5",  mq[0].size(), 5);
    cyc(1'b1, 8'h06, 1'b0, 1'b0, 1'b0);
    chk("A.cnt_ovf", 32'(a_cnt), 5);
    chk("A.ovf_set", 32'(a_ovf), 32'(ERR_EN));
    for (int i = 1; i <= 5; i++) begin
      chk("A.head_seq", 32'(a_rd), i);
      cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    end
    chk("A.empty_drain", 32'(a_empty), 1);
    chk("B.rd_last",     32'(b_rd),    5);
    chk("B.cnt_left",    32'(b_cnt),   1);
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("B.rd_flush_hold", 32'(b_rd), 5);
    chk("B.cnt_flush",     32'(b_cnt), 0);

    // Hold A at 3 entries while pointers wrap.
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'(8'h31 + i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      chk("A.wrap_head", 32'(a_rd), 32'(8'h31 + i));
      cyc(1'b1, 8'(8'h34 + i), 1'b1, 1'b0, 1'b0);
      chk("A.wrap_cnt", 32'(a_cnt), 3);
    end
    chk("A.wrap_end", 32'(a_rd), 32'h38);

    // Full with simultaneous read and write.
    cyc(1'b1, 8'h3B, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("A.fullrw_head", 32'(a_rd), 32'(8'h38 + i));
      cyc(1'b1, 8'(8'h40 + i), 1'b1, 1'b0, 1'b0);
      chk("A.fullrw_cnt", 32'(a_cnt), 5);
    end
    chk("A.fullrw_end", 32'(a_rd), 32'h3C);

    // Empty with simultaneous read and write: write wins, read not refused-counted.
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 8'hAA, 1'b1, 1'b0, 1'b0);
    chk("A.emprw_cnt",   32'(a_cnt),   1);
    chk("A.emprw_empty", 32'(a_empty), 0);
    chk("A.emprw_udf",   32'(a_udf),   0);
    chk("A.emprw_data",  32'(a_rd),    32'hAA);

    // Registered-read latency on B.
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("B.reg_rd1", 32'(b_rd), 32'h11);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("B.reg_hold", 32'(b_rd), 32'h11);
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("B.reg_rd2", 32'(b_rd), 32'h22);

    // Almost flags on B, then flush beats a concurrent write.
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= 12; i++) begin
      cyc(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
      chk("B.ae_fill", 32'(b_ae), 32'(i <= 3));
      if (i == 11) chk("B.af_11", 32'(b_af), 0);
      if (i == 12) chk("B.af_12", 32'(b_af), 1);
    end
    chk("B.cnt_12", 32'(b_cnt), 12);
    cyc(1'b1, 8'h99, 1'b0, 1'b1, 1'b0);
    chk("B.flushw_cnt",   32'(b_cnt),   0);
    chk("B.flushw_empty", 32'(b_empty), 1);
    chk("A.flushw_cnt",   32'(a_cnt),   0);

    // Random traffic with filling and draining phases.
    for (int n = 0; n < 3000; n++) begin
      case ((n / 250) % 3)
        0:       begin pw = 75; pr = 35; end
        1:       begin pw = 35; pr = 75; end
        default: begin pw = 55; pr = 55; end
      endcase
      cyc($urandom_range(0, 99) < pw, 8'($urandom), $urandom_range(0, 99) < pr,
          $urandom_range(0, 79) == 0, $urandom_range(0, 499) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
